axi_lite_reg_slave: RTL and testbench
=====================================

# axi_lite_reg_slave

AXI4-Lite slave front end that converts bus transactions into accesses on the 256 x 32-bit register bank's simple write/read port. It sits directly upstream of the register bank. It terminates all five AXI4-Lite channels and drives the bank's `write_en`/`write_addr`/`write_data`/`read_addr`. It returns the bank's combinational `read_data` on the R channel. Independent write and read FSMs allow one outstanding write and one outstanding read concurrently.

## Interface
- `ADDR_W`, 32, AXI address width and bank address width
- `DATA_W`, 32, data width; only 32 supported, `STRB_W = DATA_W/8`
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `s_awaddr`  in  ADDR_W  write address
- `s_awvalid` / `s_awready`  in / out  1  AW handshake
- `s_wdata`  in  DATA_W  write data
- `s_wstrb`  in  STRB_W  byte strobes
- `s_wvalid` / `s_wready`  in / out  1  W handshake
- `s_bresp`  out  2  write response
- `s_bvalid` / `s_bready`  out / in  1  B handshake
- `s_araddr`  in  ADDR_W  read address
- `s_arvalid` / `s_arready`  in / out  1  AR handshake
- `s_rdata`  out  DATA_W  read data
- `s_rresp`  out  2  read response
- `s_rvalid` / `s_rready`  out / in  1  R handshake
- `write_en`  out  1  bank write strobe, one cycle per accepted good write
- `write_addr`, `write_data`  out  ADDR_W, DATA_W  bank write address/data
- `read_addr`  out  ADDR_W  bank read address
- `read_data`  in  DATA_W  bank combinational read data

## Operation
- Write FSM has three states: `W_IDLE`, `W_EXEC`, `W_RESP`.
  - `W_IDLE`: AW and W are accepted independently, in either order or in the same cycle.
  - `s_awready = W_IDLE & !aw_held`; `s_wready = W_IDLE & !w_held`.
  - Address, data and strobe are latched on handshake.
  - Once both are held, or complete this cycle, the FSM moves to `W_EXEC`.
  - `W_EXEC`: evaluate the error check. If OKAY, drive `write_en=1`, `write_addr` and `write_data` for exactly this cycle. Then go to `W_RESP`.
  - `W_RESP`: `s_bvalid=1` with `s_bresp`, held stable until `s_bready`. Return to `W_IDLE` and clear the held flags.
- Write error check yields SLVERR (2'b10) and no `write_en` if any of the following hold:
  - `awaddr[1:0] != 0`
  - `awaddr[ADDR_W-1:10] != 0`
  - `wstrb != '1` (the bank has no byte enables)
- Otherwise the write response is OKAY (2'b00).
- Read FSM has three states: `R_IDLE`, `R_FETCH`, `R_RESP`.
  - `R_IDLE`: `s_arready=1`. On handshake, latch `araddr` into `read_addr` and go to `R_FETCH`.
  - `R_FETCH`: register `s_rdata <= read_data` (0 if the address is in error) and `s_rresp`. Go to `R_RESP`.
  - `R_RESP`: `s_rvalid=1`, data/resp stable until `s_rready`, then return to `R_IDLE`.
- Read error uses the same address rules as writes. An erroring read returns SLVERR with `s_rdata=0`.
- `write_addr` and `read_addr` hold their last value between accesses. `write_data` does the same.

## Timing
- Reset (asynchronous, `reset_n=0`) forces both FSMs to IDLE and clears held flags.
- Output values during reset: `s_bvalid=0`, `s_rvalid=0`, `s_bresp=0`, `s_rresp=0`, `s_rdata=0`, `write_en=0`, `write_addr=0`, `write_data=0`, `read_addr=0`.
- Ready values during and after reset: `s_awready=1`, `s_wready=1`, `s_arready=1`.
- Reset mid-transaction drops the pending response. No `write_en` occurs after reset assertion.
- Write latency:
  - The last of AW/W handshakes in cycle T.
  - `write_en` is high in T+1, and the bank captures at the end of T+1.
  - `s_bvalid` rises in T+2.
- Read latency: AR handshake in T; `s_rvalid` with data in T+2.
- Throughput: at most one write per 3 cycles and one read per 3 cycles with `bready`/`rready` tied high.
- Simultaneous write `W_EXEC` and read `R_FETCH` to the same address: the read returns the pre-write value.
- A read with AR handshake at T' ≥ T+1 returns the new value.
- VALID, once raised, is never dropped before its handshake. Response payload is constant while VALID is high.
- Backpressure on B or R does not block the other direction.

## Structure
- Shared package `axi_lite_pkg` holds:
  - `axi_resp_t` enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - `wr_state_t` and `rd_state_t` enums
  - `REG_IDX_LSB=2`, `REG_IDX_MSB=9`
- Address check as a package function `addr_ok(addr)`, shared by both FSMs.
- Single module, no sub-module. The top-level integration instantiates `axi_lite_reg_slave` feeding `reg_bank`.

## Test plan
- After reset, AW (0x0000_0010) and W (0xDEAD_BEEF, strb 0xF) in the same cycle T:
  - `write_en` pulses in T+1 with `write_addr` 0x10.
  - B returns OKAY in T+2.
  - A subsequent read of 0x10 returns 0xDEAD_BEEF, OKAY, with `rvalid` at AR+2.
- W leads AW by 3 cycles:
  - `wready` drops after the W handshake.
  - A single `write_en` occurs one cycle after AW.
  - B is OKAY.
- Errors:
  - Write to 0x0000_0400 → SLVERR, no `write_en`.
  - Write with `wstrb` 0x3 → SLVERR, no `write_en`.
  - Read of 0x0000_0002 → SLVERR, `rdata` 0.
- Backpressure with `bready=0` for 5 cycles:
  - `bvalid`/`bresp` stay stable and `awready` stays low.
  - A concurrent read completes normally.
- Same address in the same cycle:
  - A write to 0x20 (old 0x1, new 0x2) is in `W_EXEC` while a read of 0x20 is in `R_FETCH`.
  - The read returns 0x1; the next read returns 0x2.
- Assert `reset_n` low while `rvalid=1` and a write is held: `rvalid`, `bvalid` and `write_en` go to 0 immediately and all readies go to 1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and the register-bank address legality check.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rd_state_t;

  localparam int REG_IDX_LSB = 2;
  localparam int REG_IDX_MSB = 9;
  localparam int ADDR_MAX_W  = 64;

  // Word aligned and inside the 256-entry window; callers zero-extend.
  function automatic logic addr_ok(input logic [ADDR_MAX_W-1:0] addr);
    return (addr[REG_IDX_LSB-1:0] == '0) && (addr[ADDR_MAX_W-1:REG_IDX_MSB+1] == '0);
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave front end for a 256x32 register bank: independent write
// and read FSMs, one outstanding transaction in each direction.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data
);

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  axi_resp_t         bresp_q, rresp_q;

  logic              aw_hs, w_hs, wr_go, wr_ok;
  logic [ADDR_W-1:0] aw_addr_eff;
  logic [DATA_W-1:0] w_data_eff;
  logic [STRB_W-1:0] w_strb_eff;

  assign s_awready = (wr_state == W_IDLE) && !aw_held;
  assign s_wready  = (wr_state == W_IDLE) && !w_held;
  assign s_bvalid  = (wr_state == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (rd_state == R_IDLE);
  assign s_rvalid  = (rd_state == R_RESP);
  assign s_rresp   = rresp_q;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  // Bypass the holding registers when a handshake completes this cycle.
  assign aw_addr_eff = aw_hs ? s_awaddr : awaddr_q;
  assign w_data_eff  = w_hs ? s_wdata : wdata_q;
  assign w_strb_eff  = w_hs ? s_wstrb : wstrb_q;
  assign wr_go       = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok       = addr_ok(ADDR_MAX_W'(aw_addr_eff)) && (w_strb_eff == '1);

  // The check result is registered on entry to W_EXEC, so write_en and the
  // bank address/data are clean flops during the execute cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state   <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= s_awaddr;
            aw_held  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
            w_held  <= 1'b1;
          end
          if (wr_go) begin
            wr_state <= W_EXEC;
            bresp_q  <= wr_ok ? OKAY : SLVERR;
            write_en <= wr_ok;
            if (wr_ok) begin
              write_addr <= aw_addr_eff;
              write_data <= w_data_eff;
            end
          end
        end
        W_EXEC: wr_state <= W_RESP;
        W_RESP: begin
          if (s_bready) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Bank read data is combinational on read_addr and sampled in R_FETCH,
  // so a same-cycle bank write is not yet visible to the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state  <= R_IDLE;
      read_addr <= '0;
      s_rdata   <= '0;
      rresp_q   <= OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_arvalid) begin
            read_addr <= s_araddr;
            rd_state  <= R_FETCH;
          end
        end
        R_FETCH: begin
          if (addr_ok(ADDR_MAX_W'(read_addr))) begin
            s_rdata <= read_data;
            rresp_q <= OKAY;
          end else begin
            s_rdata <= '0;
            rresp_q <= SLVERR;
          end
          rd_state <= R_RESP;
        end
        R_RESP: if (s_rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: transaction-timeline model checked every
// cycle, plus directed tests with hand-computed literal expectations.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b1, s_rready = 1'b1;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        write_en;
  logic [31:0] write_addr, write_data, read_addr, read_data;

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data)
  );

  // Register bank driven by the DUT.
  logic [31:0] bank [256] = '{default: 32'h0};
  assign read_data = bank[read_addr[9:2]];
  always @(posedge clk) if (write_en) bank[write_addr[9:2]] <= write_data;

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  function automatic bit good_addr(input logic [31:0] a);
    return (a & 32'hFFFF_FC03) == 32'h0;
  endfunction

  // Model: a write is "accepted" once both AW and W have been taken; the bank
  // update lands one cycle later and the response is visible from the next.
  logic [31:0] mem [256] = '{default: 32'h0};
  bit          m_aw, m_w, m_wok, m_rok;
  int          w_age, r_age;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk1("rst_awready", s_awready, 1'b1);
      chk1("rst_wready", s_wready, 1'b1);
      chk1("rst_arready", s_arready, 1'b1);
      chk1("rst_bvalid", s_bvalid, 1'b0);
      chk1("rst_rvalid", s_rvalid, 1'b0);
      chk1("rst_write_en", write_en, 1'b0);
      chk("rst_bresp", 32'(s_bresp), 32'h0);
      chk("rst_rresp", 32'(s_rresp), 32'h0);
      chk("rst_rdata", s_rdata, 32'h0);
      chk("rst_write_addr", write_addr, 32'h0);
      chk("rst_write_data", write_data, 32'h0);
      chk("rst_read_addr", read_addr, 32'h0);
      m_aw = 0; m_w = 0; w_age = 0; r_age = 0;
    end else begin
      chk1("awready", s_awready, (w_age == 0) && !m_aw);
      chk1("wready", s_wready, (w_age == 0) && !m_w);
      chk1("arready", s_arready, r_age == 0);
      chk1("write_en", write_en, (w_age == 1) && m_wok);
      if (w_age == 1 && m_wok) begin
        chk("write_addr", write_addr, m_awaddr);
        chk("write_data", write_data, m_wdata);
      end
      chk1("bvalid", s_bvalid, w_age == 2);
      if (w_age == 2) chk("bresp", 32'(s_bresp), m_wok ? 32'h0 : 32'h2);
      chk1("rvalid", s_rvalid, r_age == 2);
      if (r_age == 2) begin
        chk("rdata", s_rdata, m_rdata);
        chk("rresp", 32'(s_rresp), m_rok ? 32'h0 : 32'h2);
      end
      if (r_age != 0) chk("read_addr", read_addr, m_araddr);
      // Read side advances first: a fetch sees memory before a same-cycle write.
      case (r_age)
        0: if (s_arvalid) begin m_araddr = s_araddr; r_age = 1; end
        1: begin
          m_rok   = good_addr(m_araddr);
          m_rdata = m_rok ? mem[m_araddr[9:2]] : 32'h0;
          r_age   = 2;
        end
        default: if (s_rready) r_age = 0;
      endcase
      case (w_age)
        0: begin
          if (!m_aw && s_awvalid) begin m_aw = 1; m_awaddr = s_awaddr; end
          if (!m_w && s_wvalid) begin m_w = 1; m_wdata = s_wdata; m_wstrb = s_wstrb; end
          if (m_aw && m_w) begin
            w_age = 1;
            m_wok = good_addr(m_awaddr) && (m_wstrb == 4'hF);
          end
        end
        1: begin
          if (m_wok) mem[m_awaddr[9:2]] = m_wdata;
          w_age = 2;
        end
        default: if (s_bready) begin w_age = 0; m_aw = 0; m_w = 0; end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, dropping any VALID whose handshake completed.
  task automatic hs_step();
    bit af, wf, rf;
    af = s_awvalid && s_awready;
    wf = s_wvalid && s_wready;
    rf = s_arvalid && s_arready;
    step();
    if (af) s_awvalid = 1'b0;
    if (wf) s_wvalid = 1'b0;
    if (rf) s_arvalid = 1'b0;
  endtask

  task automatic hs_wait();
    int n = 0;
    while ((s_awvalid || s_wvalid || s_arvalid) && n < 40) begin
      hs_step();
      n++;
    end
    chk1("hs_done", s_awvalid || s_wvalid || s_arvalid, 1'b0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input logic exp_we);
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    if (lead > 0) begin
      for (int i = 0; i < lead; i++) hs_step();
      chk1("wready_after_w", s_wready, 1'b0);
    end
    s_awaddr = a; s_awvalid = 1'b1;
    hs_wait();
    chk1("we_pulse", write_en, exp_we);
    if (exp_we) chk("we_addr", write_addr, a);
  endtask

  task automatic read_txn(input logic [31:0] a);
    s_araddr = a; s_arvalid = 1'b1;
    hs_wait();
  endtask

  task automatic wait_b(input string nm, input logic [1:0] exp_resp);
    int n = 0;
    while (!s_bvalid && n < 20) begin step(); n++; end
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_resp"}, 32'(s_bresp), 32'(exp_resp));
  endtask

  task automatic wait_r(input string nm, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    int n = 0;
    while (!s_rvalid && n < 20) begin step(); n++; end
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_data"}, s_rdata, exp_d);
    chk({nm, "_resp"}, 32'(s_rresp), 32'(exp_resp));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Same-cycle AW/W, then read back.
    write_txn(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
    wait_b("t1_b", 2'b00);
    step();
    read_txn(32'h10);
    wait_r("t1_r", 32'hDEAD_BEEF, 2'b00);
    step();

    // W leads AW by three cycles.
    write_txn(32'h14, 32'h1234_5678, 4'hF, 3, 1'b1);
    wait_b("t2_b", 2'b00);
    step();

    // Error cases.
    write_txn(32'h400, 32'h0000_0011, 4'hF, 0, 1'b0);
    wait_b("t3_b_range", 2'b10);
    step();
    write_txn(32'h18, 32'h0000_0022, 4'h3, 0, 1'b0);
    wait_b("t3_b_strb", 2'b10);
    step();
    read_txn(32'h2);
    wait_r("t3_r_unal", 32'h0, 2'b10);
    step();
    read_txn(32'h18);
    wait_r("t3_r_nowrite", 32'h0, 2'b00);
    step();

    // B backpressure with a concurrent read.
    s_bready = 1'b0;
    write_txn(32'h24, 32'hA5A5_A5A5, 4'hF, 0, 1'b1);
    wait_b("t4_b", 2'b00);
    read_txn(32'h10);
    wait_r("t4_r", 32'hDEAD_BEEF, 2'b00);
    repeat (3) step();
    chk1("t4_bvalid_held", s_bvalid, 1'b1);
    chk1("t4_awready_low", s_awready, 1'b0);
    chk("t4_bresp_held", 32'(s_bresp), 32'h0);
    s_bready = 1'b1;
    step();
    chk1("t4_bvalid_done", s_bvalid, 1'b0);

    // Write execute and read fetch to the same address in the same cycle.
    write_txn(32'h20, 32'h1, 4'hF, 0, 1'b1);
    wait_b("t5_b", 2'b00);
    step();
    s_awaddr = 32'h20; s_wdata = 32'h2; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h20; s_arvalid = 1'b1;
    hs_wait();
    chk1("t5_we", write_en, 1'b1);
    wait_r("t5_r_old", 32'h1, 2'b00);
    step();
    read_txn(32'h20);
    wait_r("t5_r_new", 32'h2, 2'b00);
    step();

    // Reset while R is stalled and W is held.
    s_rready = 1'b0;
    read_txn(32'h14);
    wait_r("t6_r", 32'h1234_5678, 2'b00);
    step();
    chk1("t6_rvalid_held", s_rvalid, 1'b1);
    s_wdata = 32'h5555_5555; s_wstrb = 4'hF; s_wvalid = 1'b1;
    hs_step();
    chk1("t6_w_held", s_wready, 1'b0);
    reset_n = 1'b0;
    s_wvalid = 1'b0;
    #1;
    chk1("t6_rst_rvalid", s_rvalid, 1'b0);
    chk1("t6_rst_bvalid", s_bvalid, 1'b0);
    chk1("t6_rst_we", write_en, 1'b0);
    chk1("t6_rst_awready", s_awready, 1'b1);
    chk1("t6_rst_wready", s_wready, 1'b1);
    chk1("t6_rst_arready", s_arready, 1'b1);
    s_rready = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    write_txn(32'h28, 32'hCAFE_F00D, 4'hF, 0, 1'b1);
    wait_b("t6_b_after", 2'b00);
    step();
    read_txn(32'h28);
    wait_r("t6_r_after", 32'hCAFE_F00D, 2'b00);
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
